ahb_sram_slave: RTL and testbench
=================================

# ahb_sram_slave

AHB-Lite word-addressed SRAM slave that acts as the bus target for the master-side driver signals (`haddr`, `htrans`, `hwrite`, `hsize`, `hburst`, `hprot`, `hwdata`).
- Returns `hrdata`, `hready` (as `hreadyout`) and `hresp`.
- Supports configurable wait states, byte/halfword/word writes and two-cycle ERROR responses.
- Serves as the DUT behind the bus interface used by the driver and monitor.

## Interface
Parameters:
- `AW`, 32: address bus width.
- `DW`, 32: data bus width; only 32 is supported.
- `RW`, 2: `hresp` width. OKAY = 2'b00, ERROR = 2'b01.
- `DEPTH`, 256: memory depth in DW-bit words.
- `WAIT_STATES`, 1: wait cycles per valid transfer, range 0..7.

Ports:
- `hclk`, in, 1: clock. Single clock domain, rising edge.
- `hresetn`, in, 1: reset. Asynchronous, active-low.
- `hsel`, in, 1: slave select.
- `haddr`, in, AW: byte address.
- `htrans`, in, 2: IDLE 00, BUSY 01, NONSEQ 10, SEQ 11.
- `hwrite`, in, 1: 1 = write.
- `hsize`, in, 3: 0 = byte, 1 = half, 2 = word.
- `hburst`, in, 3: accepted, ignored.
- `hprot`, in, 4: accepted, ignored.
- `hwdata`, in, DW: write data, valid in the data phase.
- `hready`, in, 1: bus-level ready (previous transfer complete).
- `hreadyout`, out, 1: this slave's ready.
- `hrdata`, out, DW: read data.
- `hresp`, out, RW: response.

## Operation
- **Address-phase sample:** occurs on a rising edge where `hsel & hready & htrans[1]`. The block registers addr, write, size and the byte-lane mask.
- **Errored transfer:** any of the following marks the transfer as errored; no memory access takes place.
  - `haddr[AW-1:2] >= DEPTH`.
  - `hsize > 2`.
  - Misalignment: half with `haddr[0]=1`, or word with `haddr[1:0]!=0`.
- **IDLE/BUSY, or `hsel=0` with `hready=1`:** no transfer. Next cycle gives `hreadyout=1`, `hresp=OKAY`.
- **Byte lanes (little-endian):**
  - Byte: lane `haddr[1:0]`.
  - Half: lanes `{haddr[1],0}` and `+1`.
  - Word: all four lanes.
- **FSM states:**
  - `IDLE`: `hreadyout=1`, OKAY.
  - `WAIT`: `hreadyout=0`, OKAY. A counter counts down from WAIT_STATES.
  - `DATA`: `hreadyout=1`, OKAY. Transfer completes here.
  - `ERR1`: `hreadyout=0`, ERROR.
  - `ERR2`: `hreadyout=1`, ERROR.
- **FSM transitions:**
  - On a sample: an errored transfer goes to `ERR1`. Otherwise it goes to `WAIT` if WAIT_STATES>0, else to `DATA`.
  - `WAIT` goes to `DATA` when the count reaches 1.
  - `ERR1` goes to `ERR2`.
  - `DATA`/`ERR2` go to `WAIT`/`DATA`/`ERR1` if a new sample happens on the same edge; otherwise they go to `IDLE`.
- **Write:** `hwdata` lanes are written into memory on the edge that ends `DATA`.
- **Read:** the memory word is registered into `hrdata` on the address-sample edge and held until the next read sample. A write completing on that same edge to the same word is forwarded lane-wise into `hrdata`.
- **Unaccessed lanes:** `hrdata` carries the full word. Unaccessed lanes are not zeroed.
- **Pipelining:** the next address phase overlaps the current data phase. No dead cycle is inserted between back-to-back transfers.
- **`hburst`:** SEQ is treated exactly like NONSEQ; `hburst` is not checked.

## Timing
- **Reset values:**
  - `hreadyout=1`, `hresp=OKAY`, `hrdata=0`.
  - FSM in `IDLE`, wait counter 0.
  - Memory contents are not reset.
- **Mid-operation reset:** asserting `hresetn` mid-transfer forces the reset values immediately (asynchronous). A pending write is dropped. Release is synchronous to the next `hclk` edge.
- **Latency:** a valid transfer sampled at edge E completes with `hreadyout=1` in the cycle after edge E+WAIT_STATES, i.e. WAIT_STATES+1 data-phase cycles.
- **Error:** exactly two data-phase cycles: ERROR with `hreadyout=0`, then ERROR with `hreadyout=1`.
- **No new sample** while `hreadyout=0`, since `hready` is low.
- **`hready` from another slave:** when `hready=0` is driven by another slave, the block does not sample and holds `IDLE`.
- **Write followed by read:** a read of the same word issued back-to-back after a write returns the new data in every WAIT_STATES setting.

## Test plan
- **Reset outputs:** `hresetn=0` -> `hreadyout=1`, `hresp=00`, `hrdata=0`.
- **Word write/read:** WAIT_STATES=1; word write 0xDEADBEEF to 0x10, then read 0x10 -> one wait cycle on each transfer; read returns 0xDEADBEEF.
- **Back-to-back forwarding:** WAIT_STATES=0; byte write 0xAA to 0x13 immediately followed by word read of 0x10 (prior contents 0x11223344) -> returns 0xAA223344 in the next cycle.
- **Errors:** read 0x400 (DEPTH=256) and word read 0x02 -> each gives ERROR, `hreadyout` 0 then 1; memory is unchanged.
- **No transfer:** IDLE, BUSY, and `hsel=0` cycles -> `hreadyout=1`, OKAY, no write.
- **Reset mid-transfer:** assert `hresetn` during `WAIT` of a write to 0x20 -> outputs go to reset values, and word 0x20 keeps its old value.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// AHB-Lite word-addressed SRAM slave with configurable wait states, byte-lane writes
// and a two-cycle ERROR response for out-of-range, oversized or misaligned transfers.
module ahb_sram_slave #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int RW          = 2,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic          hclk,
  input  logic          hresetn,
  input  logic          hsel,
  input  logic [AW-1:0] haddr,
  input  logic [1:0]    htrans,
  input  logic          hwrite,
  input  logic [2:0]    hsize,
  input  logic [2:0]    hburst,
  input  logic [3:0]    hprot,
  input  logic [DW-1:0] hwdata,
  input  logic          hready,
  output logic          hreadyout,
  output logic [DW-1:0] hrdata,
  output logic [RW-1:0] hresp
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [RW-1:0] RESP_OKAY  = RW'(0);
  localparam logic [RW-1:0] RESP_ERROR = RW'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  logic [DW-1:0] mem [0:DEPTH-1];

  state_t        state_reg, state_next;
  logic [2:0]    cnt_reg, cnt_next;
  logic [IW-1:0] addr_reg;
  logic          write_reg;
  logic [3:0]    mask_reg;

  logic [IW-1:0] idx;
  logic [3:0]    lane_mask;
  logic          sample;
  logic          xfer_err;
  logic          wr_fire;
  logic          fwd_hit;
  logic [DW-1:0] mem_rd;
  logic [DW-1:0] rd_word;
  logic          unused_ok;

  assign unused_ok = &{1'b0, hburst, hprot};

  // Gating on our own ready keeps WAIT/ERR1 immune to a misbehaving hready.
  assign sample   = hsel & hready & htrans[1] & hreadyout;
  assign idx      = haddr[IW+1:2];
  assign xfer_err = ({2'b00, haddr[AW-1:2]} >= AW'(DEPTH))
                  | (hsize > 3'd2)
                  | ((hsize == 3'd1) & haddr[0])
                  | ((hsize == 3'd2) & (haddr[1:0] != 2'b00));

  always_comb begin
    lane_mask = 4'b1111;
    case (hsize)
      3'd0:    lane_mask = 4'b0001 << haddr[1:0];
      3'd1:    lane_mask = haddr[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  end

  assign wr_fire = (state_reg == ST_DATA) & write_reg;
  assign fwd_hit = wr_fire & (addr_reg == idx);
  assign mem_rd  = mem[idx];

  // A write retiring on the read-sample edge wins on the lanes it touches.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_fwd
      assign rd_word[gi*8 +: 8] = (fwd_hit & mask_reg[gi]) ? hwdata[gi*8 +: 8]
                                                           : mem_rd[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        state_next = ST_IDLE;
        if (sample) begin
          if (xfer_err) begin
            state_next = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_next = ST_WAIT;
            cnt_next   = 3'(WAIT_STATES);
          end else begin
            state_next = ST_DATA;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_reg <= 3'd1) begin
          state_next = ST_DATA;
          cnt_next   = 3'd0;
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end
      ST_ERR1: state_next = ST_ERR2;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    hreadyout = 1'b1;
    hresp     = RESP_OKAY;
    case (state_reg)
      ST_WAIT: hreadyout = 1'b0;
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = RESP_ERROR;
      end
      ST_ERR2: hresp = RESP_ERROR;
      default: begin
        hreadyout = 1'b1;
        hresp     = RESP_OKAY;
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 3'd0;
      addr_reg  <= '0;
      write_reg <= 1'b0;
      mask_reg  <= 4'b0000;
      hrdata    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (sample) begin
        addr_reg  <= idx;
        write_reg <= hwrite & ~xfer_err;
        mask_reg  <= lane_mask;
        if (!hwrite && !xfer_err) begin
          hrdata <= rd_word;
        end
      end
    end
  end

  // Contents survive reset; an in-flight write dies with state_reg.
  always_ff @(posedge hclk) begin
    if (wr_fire) begin
      for (int b = 0; b < 4; b++) begin
        if (mask_reg[b]) begin
          mem[addr_reg][b*8 +: 8] <= hwdata[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: instance 0 uses one wait state, instance 1 none,
// both driven by a single-master model whose hready is the slave's own hreadyout.
module tb_ahb_sram_slave;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel         [2];
  logic [31:0] haddr        [2];
  logic [1:0]  htrans       [2];
  logic        hwrite       [2];
  logic [2:0]  hsize        [2];
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata       [2];
  logic        hready       [2];
  logic        hready_force [2];
  logic        hreadyout    [2];
  logic [31:0] hrdata       [2];
  logic [1:0]  hresp        [2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 hclk = ~hclk;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      assign hready[gi] = hreadyout[gi] & hready_force[gi];
      ahb_sram_slave #(
        .AW(32), .DW(32), .RW(2), .DEPTH(256),
        .WAIT_STATES((gi == 0) ? 1 : 0)
      ) u_dut (
        .hclk     (hclk),
        .hresetn  (hresetn),
        .hsel     (hsel[gi]),
        .haddr    (haddr[gi]),
        .htrans   (htrans[gi]),
        .hwrite   (hwrite[gi]),
        .hsize    (hsize[gi]),
        .hburst   (hburst),
        .hprot    (hprot),
        .hwdata   (hwdata[gi]),
        .hready   (hready[gi]),
        .hreadyout(hreadyout[gi]),
        .hrdata   (hrdata[gi]),
        .hresp    (hresp[gi])
      );
    end
  endgenerate

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_idle(input int u);
    hsel[u]   = 1'b0;
    htrans[u] = 2'b00;
    hwrite[u] = 1'b0;
    haddr[u]  = 32'h0;
    hsize[u]  = 3'd2;
  endtask

  task automatic addr_phase(input int u, input logic wr, input logic [31:0] a, input logic [2:0] sz);
    hsel[u]   = 1'b1;
    htrans[u] = 2'b10;
    hwrite[u] = wr;
    haddr[u]  = a;
    hsize[u]  = sz;
  endtask

  task automatic wait_ready(input int u, input string tag, output int n);
    n = 0;
    while (!hreadyout[u] && n < 16) begin
      n++;
      @(negedge hclk);
    end
    if (!hreadyout[u]) check({tag, " timeout"}, 32'd0, 32'd1);
  endtask

  // One isolated transfer; checks both response cycles, wait count and read data.
  task automatic do_xfer(input int u, input logic wr, input logic [31:0] a, input logic [2:0] sz,
                         input logic [31:0] wd, input logic exp_err, input int exp_waits,
                         input logic chk_rd, input logic [31:0] exp_rd, input string tag);
    logic [1:0] resp_first, resp_last;
    int waits;
    @(negedge hclk);
    addr_phase(u, wr, a, sz);
    @(negedge hclk);
    bus_idle(u);
    hwdata[u]  = wd;
    resp_first = hresp[u];
    wait_ready(u, tag, waits);
    resp_last = hresp[u];
    $display("u%0d %s %s addr=0x%08h size=%0d wdata=0x%08h rdata=0x%08h resp=%0d/%0d waits=%0d",
             u, tag, wr ? "WR" : "RD", a, sz, wd, hrdata[u], resp_first, resp_last, waits);
    check({tag, " resp1"}, 32'(resp_first), exp_err ? 32'd1 : 32'd0);
    check({tag, " resp2"}, 32'(resp_last), exp_err ? 32'd1 : 32'd0);
    check({tag, " waits"}, 32'(waits), 32'(exp_waits));
    if (chk_rd) check({tag, " rdata"}, hrdata[u], exp_rd);
  endtask

  // Write immediately followed by a read of the same word, overlapping phases.
  task automatic wr_rd_b2b(input int u, input logic [31:0] a, input logic [31:0] wd, input string tag);
    int n;
    @(negedge hclk);
    addr_phase(u, 1'b1, a, 3'd2);
    @(negedge hclk);
    hwdata[u] = wd;
    addr_phase(u, 1'b0, a, 3'd2);
    wait_ready(u, {tag, " wr"}, n);
    @(negedge hclk);
    bus_idle(u);
    wait_ready(u, {tag, " rd"}, n);
    $display("u%0d %s WR+RD addr=0x%08h wdata=0x%08h rdata=0x%08h", u, tag, a, wd, hrdata[u]);
    check(tag, hrdata[u], wd);
  endtask

  logic        nt_hsel  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  logic [1:0]  nt_trans [4] = '{2'b00, 2'b01, 2'b10, 2'b10};
  logic        nt_force [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    hburst  = 3'b000;
    hprot   = 4'b0011;
    hresetn = 1'b1;
    for (int u = 0; u < 2; u++) begin
      bus_idle(u);
      hwdata[u]       = 32'h0;
      hready_force[u] = 1'b1;
    end
    #1 hresetn = 1'b0;
    #11;
    check("rst hreadyout", 32'(hreadyout[0]), 32'd1);
    check("rst hresp", 32'(hresp[0]), 32'd0);
    check("rst hrdata0", hrdata[0], 32'h0);
    check("rst hrdata1", hrdata[1], 32'h0);
    @(negedge hclk);
    hresetn = 1'b1;

    // Word, half and byte writes with one wait state.
    do_xfer(0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 1'b0, 1, 1'b0, 32'h0, "word wr");
    do_xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, 1'b0, 1, 1'b1, 32'hDEADBEEF, "word rd");
    do_xfer(0, 1'b1, 32'h12, 3'd1, 32'h12340000, 1'b0, 1, 1'b0, 32'h0, "half wr");
    do_xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, 1'b0, 1, 1'b1, 32'h1234BEEF, "half rd");
    do_xfer(0, 1'b1, 32'h11, 3'd0, 32'h00007700, 1'b0, 1, 1'b0, 32'h0, "byte wr");
    do_xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, 1'b0, 1, 1'b1, 32'h123477EF, "byte rd");

    // Error responses leave memory untouched.
    do_xfer(0, 1'b1, 32'h00, 3'd2, 32'hCAFEF00D, 1'b0, 1, 1'b0, 32'h0, "err setup");
    do_xfer(0, 1'b0, 32'h400, 3'd2, 32'h0, 1'b1, 1, 1'b0, 32'h0, "err range");
    do_xfer(0, 1'b0, 32'h02, 3'd2, 32'h0, 1'b1, 1, 1'b0, 32'h0, "err word align");
    do_xfer(0, 1'b1, 32'h02, 3'd2, 32'hFFFFFFFF, 1'b1, 1, 1'b0, 32'h0, "err wr align");
    do_xfer(0, 1'b1, 32'h01, 3'd1, 32'hFFFFFFFF, 1'b1, 1, 1'b0, 32'h0, "err half align");
    do_xfer(0, 1'b1, 32'h00, 3'd3, 32'hFFFFFFFF, 1'b1, 1, 1'b0, 32'h0, "err size");
    do_xfer(0, 1'b0, 32'h00, 3'd2, 32'h0, 1'b0, 1, 1'b1, 32'hCAFEF00D, "err mem kept");

    // IDLE, BUSY, deselected and foreign-hready cycles must not start a transfer.
    for (int i = 0; i < 4; i++) begin
      @(negedge hclk);
      hsel[0]         = nt_hsel[i];
      htrans[0]       = nt_trans[i];
      hwrite[0]       = 1'b1;
      haddr[0]        = 32'h10;
      hsize[0]        = 3'd2;
      hready_force[0] = nt_force[i];
      @(negedge hclk);
      bus_idle(0);
      hready_force[0] = 1'b1;
      hwdata[0]       = 32'h0;
      $display("u0 notransfer hsel=%0d htrans=%0d hready=%0d hreadyout=%0d hresp=%0d",
               nt_hsel[i], nt_trans[i], nt_force[i], hreadyout[0], hresp[0]);
      check($sformatf("notransfer%0d hreadyout", i), 32'(hreadyout[0]), 32'd1);
      check($sformatf("notransfer%0d hresp", i), 32'(hresp[0]), 32'd0);
    end
    do_xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, 1'b0, 1, 1'b1, 32'h123477EF, "notransfer mem");

    // Back-to-back write then read of the same word, both wait settings.
    wr_rd_b2b(0, 32'h30, 32'h0BADF00D, "b2b ws1");
    wr_rd_b2b(1, 32'h30, 32'h13579BDF, "b2b ws0");

    // Byte write to 0x13 forwarded into a word read of 0x10 on the next cycle.
    do_xfer(1, 1'b1, 32'h10, 3'd2, 32'h11223344, 1'b0, 0, 1'b0, 32'h0, "fwd setup");
    @(negedge hclk);
    addr_phase(1, 1'b1, 32'h13, 3'd0);
    @(negedge hclk);
    hwdata[1] = 32'hAA000000;
    addr_phase(1, 1'b0, 32'h10, 3'd2);
    @(negedge hclk);
    bus_idle(1);
    $display("u1 fwd byte wr 0x13 + rd 0x10 rdata=0x%08h hreadyout=%0d", hrdata[1], hreadyout[1]);
    check("fwd hreadyout", 32'(hreadyout[1]), 32'd1);
    check("fwd rdata", hrdata[1], 32'hAA223344);
    do_xfer(1, 1'b0, 32'h10, 3'd2, 32'h0, 1'b0, 0, 1'b1, 32'hAA223344, "fwd mem");

    // Reset asserted during the wait state of a write drops that write.
    do_xfer(0, 1'b1, 32'h20, 3'd2, 32'h5A5A5A5A, 1'b0, 1, 1'b0, 32'h0, "mrst setup");
    do_xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, 1'b0, 1, 1'b1, 32'h123477EF, "mrst pre rd");
    @(negedge hclk);
    addr_phase(0, 1'b1, 32'h20, 3'd2);
    @(negedge hclk);
    bus_idle(0);
    hwdata[0] = 32'hFFFFFFFF;
    check("mrst in wait", 32'(hreadyout[0]), 32'd0);
    #2 hresetn = 1'b0;
    #1;
    $display("u0 midreset hreadyout=%0d hresp=%0d hrdata=0x%08h", hreadyout[0], hresp[0], hrdata[0]);
    check("mrst hreadyout", 32'(hreadyout[0]), 32'd1);
    check("mrst hresp", 32'(hresp[0]), 32'd0);
    check("mrst hrdata", hrdata[0], 32'h0);
    @(negedge hclk);
    @(negedge hclk);
    hresetn = 1'b1;
    do_xfer(0, 1'b0, 32'h20, 3'd2, 32'h0, 1'b0, 1, 1'b1, 32'h5A5A5A5A, "mrst mem kept");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
